// File: rtl/ai_i2s_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ai_i2s_tx_frame_ctrl
// Description : Upstream sequencer for ai_i2s_bit_serializer. It pulls stereo
//               sample pairs over valid/ready, generates SCK and WS from clk,
//               and issues one serializer load per channel slot plus one
//               clk_en pulse per remaining SCK falling edge. A missing pair
//               at a left boundary is replaced by zeros and flags underrun.
// Ports       : clk, rst_n (sync, active low), enable
//               clk_div / word_len / slot_len   - config, latched on start
//               s_valid, s_ready, s_left, s_right - sample pair stream
//               ser_load, ser_data, ser_num_bits, ser_clk_en - serializer side
//               sck_out, ws_out                 - I2S bit clock, word select
//               underrun, underrun_clr          - sticky underrun flag
// Options     : define I2S_LJ_MODE_EN to add input fmt_lj (left-justified
//               framing when latched high).
// Revision    : 1.0 - initial release
// ============================================================================
module ai_i2s_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
`ifdef I2S_LJ_MODE_EN
    input  logic                  fmt_lj,
`endif
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [5:0]            word_len,
    input  logic [5:0]            slot_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    output logic                  ser_load,
    output logic [DATA_WIDTH-1:0] ser_data,
    output logic [5:0]            ser_num_bits,
    output logic                  ser_clk_en,
    output logic                  sck_out,
    output logic                  ws_out,
    output logic                  underrun,
    input  logic                  underrun_clr
);

    localparam logic [5:0] c_DW = 6'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_clk_div;
    logic [5:0]            r_wl;
    logic [5:0]            r_sl;
    logic                  r_lj;
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic [5:0]            r_bit_idx;
    logic                  r_chan;    // channel of the next boundary: 0 = left
    logic                  r_fresh;   // latched pair not yet started
    logic                  r_zero;    // current frame is an underrun frame
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;

    logic [5:0]            w_wl;
    logic [5:0]            w_sl;
    logic                  w_lj_in;
    logic                  w_hs;
    logic                  w_wrap;
    logic                  w_fall;
    logic                  w_boundary;
    logic                  w_last;
    logic                  w_ws_evt;
    logic                  w_ur_set;
    logic [6:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_left_src;
    logic [DATA_WIDTH-1:0] w_left_word;
    logic [DATA_WIDTH-1:0] w_right_word;

`ifdef I2S_LJ_MODE_EN
    assign w_lj_in = fmt_lj;
`else
    assign w_lj_in = 1'b0;
`endif

    // Effective config clamping
    assign w_wl = (word_len == 6'd0 || word_len > c_DW) ? c_DW : word_len;
    assign w_sl = (slot_len < w_wl) ? w_wl : slot_len;

    assign w_hs       = s_valid & s_ready;
    assign w_wrap     = (r_state == S_RUN) && (r_div_cnt == r_clk_div);
    assign w_fall     = w_wrap && sck_out;
    assign w_boundary = w_fall && (r_bit_idx == 6'd0);
    assign w_last     = w_fall && (r_bit_idx == r_sl - 6'd1);
    // I2S moves WS one bit ahead of the MSB; left-justified moves it with the MSB
    assign w_ws_evt   = r_lj ? w_boundary : w_last;
    assign w_ur_set   = w_boundary && !r_chan && !r_fresh && !w_hs;

    // MSB-align: shifting left drops any bits above the valid word length
    assign w_shamt      = 7'(DATA_WIDTH) - {1'b0, r_wl};
    assign w_left_src   = w_hs ? s_left : r_left;
    assign w_left_word  = w_left_src << w_shamt;
    assign w_right_word = r_right << w_shamt;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            r_state      <= S_IDLE;
            r_clk_div    <= '0;
            r_wl         <= '0;
            r_sl         <= '0;
            r_lj         <= 1'b0;
            r_div_cnt    <= '0;
            r_bit_idx    <= '0;
            r_chan       <= 1'b0;
            r_fresh      <= 1'b0;
            r_zero       <= 1'b0;
            r_left       <= '0;
            r_right      <= '0;
            s_ready      <= 1'b0;
            ser_load     <= 1'b0;
            ser_data     <= '0;
            ser_num_bits <= '0;
            ser_clk_en   <= 1'b0;
            sck_out      <= 1'b0;
            ws_out       <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            ser_load   <= 1'b0;
            ser_clk_en <= 1'b0;
            // A set in the same cycle as a clear wins
            underrun   <= w_ur_set | (underrun & ~underrun_clr);

            case (r_state)
                S_IDLE: begin
                    r_clk_div    <= clk_div;
                    r_wl         <= w_wl;
                    r_sl         <= w_sl;
                    r_lj         <= w_lj_in;
                    ser_num_bits <= w_wl;
                    s_ready      <= 1'b1;
                    r_state      <= S_FETCH;
                end

                S_FETCH: begin
                    if (w_hs) begin
                        r_left  <= s_left;
                        r_right <= s_right;
                        r_fresh <= 1'b1;
                        s_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (w_wrap) begin
                        r_div_cnt <= '0;
                        sck_out   <= ~sck_out;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
                    end

                    if (w_fall) begin
                        r_bit_idx  <= (r_bit_idx == r_sl - 6'd1) ? 6'd0 : r_bit_idx + 6'd1;
                        ser_clk_en <= !w_boundary;
                    end

                    // Away from a boundary r_chan already names the next slot;
                    // on a boundary it still names the slot being loaded.
                    if (w_ws_evt) begin
                        ws_out <= (w_boundary && !r_lj) ? ~r_chan : r_chan;
                    end

                    if (w_boundary) begin
                        ser_load <= 1'b1;
                        r_chan   <= ~r_chan;
                        if (!r_chan) begin
                            s_ready <= 1'b0;
                            r_fresh <= 1'b0;
                            if (r_fresh || w_hs) begin
                                ser_data <= w_left_word;
                                r_zero   <= 1'b0;
                            end else begin
                                ser_data <= '0;
                                r_zero   <= 1'b1;
                            end
                            if (w_hs) begin
                                r_left  <= s_left;
                                r_right <= s_right;
                            end
                        end else begin
                            ser_data <= r_zero ? '0 : w_right_word;
                            s_ready  <= 1'b1;
                        end
                    end else if (w_hs) begin
                        // Right slot is already loaded, so the pair regs are free
                        r_left  <= s_left;
                        r_right <= s_right;
                        r_fresh <= 1'b1;
                        s_ready <= 1'b0;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
